ans_delay_timer_mc: RTL and testbench

//  Multi-channel answer-delay timer for the UART core. Each channel measures the

---
 rtl/ans_delay_timer_mc.sv | 150 +++++++++++++++
 tb/tb_ans_delay_timer_mc.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ans_delay_timer_mc.sv
// Multi-channel answer-delay timer. There is one shared tick prescaler, and each
// channel runs its own delay counter/FSM. The channel state is stored triplicated.
module ans_delay_timer_mc #(
  parameter int CH_NUM  = 4,
  parameter int CNT_W   = 16,
  parameter int PRESC_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PRESC_W-1:0]      tick_div_i,
  input  logic [CH_NUM-1:0]       start_i,
  input  logic [CH_NUM-1:0]       hold_i,
  input  logic [CH_NUM-1:0]       clear_i,
  input  logic [CH_NUM*CNT_W-1:0] timeout_set_i,
  output logic [CH_NUM*CNT_W-1:0] cnt_o,
  output logic [CH_NUM*CNT_W-1:0] peak_o,
  output logic [CH_NUM-1:0]       timeout_o,
  output logic [CH_NUM-1:0]       timeout_p_o,
  output logic [CH_NUM-1:0]       ovf_o,
  output logic [CH_NUM-1:0]       busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COUNT   = 2'd1,
    ST_HOLD    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  logic [PRESC_W-1:0] r_presc;
  logic               w_tick;

  // The compare is live, so a divider lowered below the current phase wraps without a tick.
  assign w_tick = (r_presc == tick_div_i);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_presc <= '0;
    end else if (r_presc >= tick_div_i) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  genvar gi;
  for (gi = 0; gi < CH_NUM; gi++) begin : gen_ch
    logic [1:0]       r_st_a, r_st_b, r_st_c;
    logic [CNT_W-1:0] r_cnt_a, r_cnt_b, r_cnt_c;
    logic [CNT_W-1:0] r_peak_a, r_peak_b, r_peak_c;
    logic             r_ovf_a, r_ovf_b, r_ovf_c;
    logic [CNT_W-1:0] r_cnt_q, r_peak_q;
    logic             r_to_q, r_top_q, r_ovf_q, r_busy_q;

    state_t           w_st, w_st_next;
    logic [CNT_W-1:0] w_cnt, w_peak, w_cnt_next, w_peak_next, w_inc, w_set;
    logic             w_ovf, w_ovf_next, w_top_next;

    // 2-of-3 majority; the next state is always derived from the voted copy.
    assign w_st   = state_t'((r_st_a & r_st_b) | (r_st_a & r_st_c) | (r_st_b & r_st_c));
    assign w_cnt  = (r_cnt_a & r_cnt_b) | (r_cnt_a & r_cnt_c) | (r_cnt_b & r_cnt_c);
    assign w_peak = (r_peak_a & r_peak_b) | (r_peak_a & r_peak_c) | (r_peak_b & r_peak_c);
    assign w_ovf  = (r_ovf_a & r_ovf_b) | (r_ovf_a & r_ovf_c) | (r_ovf_b & r_ovf_c);
    assign w_inc  = w_cnt + 1'b1;
    assign w_set  = timeout_set_i[gi*CNT_W +: CNT_W];

    always_comb begin
      w_st_next   = w_st;
      w_cnt_next  = w_cnt;
      w_peak_next = w_peak;
      w_ovf_next  = w_ovf;
      w_top_next  = 1'b0;
      if (clear_i[gi]) begin
        w_st_next   = ST_IDLE;
        w_cnt_next  = '0;
        w_peak_next = '0;
        w_ovf_next  = 1'b0;
      end else if (start_i[gi]) begin
        w_st_next  = ST_COUNT;
        w_cnt_next = '0;
        w_ovf_next = 1'b0;
      end else if (w_st == ST_COUNT) begin
        if (hold_i[gi]) begin
          w_st_next = ST_HOLD;
          if (w_cnt > w_peak) w_peak_next = w_cnt;
        end else if (w_tick) begin
          w_cnt_next = w_inc;
          if ((w_set != '0) && (w_inc >= w_set)) begin
            w_st_next  = ST_TIMEOUT;
            w_top_next = 1'b1;
          end else if (&w_inc) begin
            w_st_next   = ST_HOLD;
            w_ovf_next  = 1'b1;
            w_peak_next = '1;
          end
        end
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_st_a   <= ST_IDLE;
        r_st_b   <= ST_IDLE;
        r_st_c   <= ST_IDLE;
        r_cnt_a  <= '0;
        r_cnt_b  <= '0;
        r_cnt_c  <= '0;
        r_peak_a <= '0;
        r_peak_b <= '0;
        r_peak_c <= '0;
        r_ovf_a  <= 1'b0;
        r_ovf_b  <= 1'b0;
        r_ovf_c  <= 1'b0;
        r_cnt_q  <= '0;
        r_peak_q <= '0;
        r_to_q   <= 1'b0;
        r_top_q  <= 1'b0;
        r_ovf_q  <= 1'b0;
        r_busy_q <= 1'b0;
      end else begin
        r_st_a   <= w_st_next;
        r_st_b   <= w_st_next;
        r_st_c   <= w_st_next;
        r_cnt_a  <= w_cnt_next;
        r_cnt_b  <= w_cnt_next;
        r_cnt_c  <= w_cnt_next;
        r_peak_a <= w_peak_next;
        r_peak_b <= w_peak_next;
        r_peak_c <= w_peak_next;
        r_ovf_a  <= w_ovf_next;
        r_ovf_b  <= w_ovf_next;
        r_ovf_c  <= w_ovf_next;
        r_cnt_q  <= w_cnt_next;
        r_peak_q <= w_peak_next;
        r_to_q   <= (w_st_next == ST_TIMEOUT);
        r_top_q  <= w_top_next;
        r_ovf_q  <= w_ovf_next;
        r_busy_q <= (w_st_next == ST_COUNT);
      end
    end

    assign cnt_o[gi*CNT_W +: CNT_W]  = r_cnt_q;
    assign peak_o[gi*CNT_W +: CNT_W] = r_peak_q;
    assign timeout_o[gi]             = r_to_q;
    assign timeout_p_o[gi]           = r_top_q;
    assign ovf_o[gi]                 = r_ovf_q;
    assign busy_o[gi]                = r_busy_q;
  end

endmodule

// File: tb/tb_ans_delay_timer_mc.sv
// Bench for ans_delay_timer_mc: directed scenarios plus a randomized run,
// checked against a per-channel behavioural model.
module tb_ans_delay_timer_mc;
  localparam int CH  = 4;
  localparam int CW  = 8;
  localparam int PW  = 16;
  localparam int MOD = 1 << CW;
  localparam int S_IDLE = 0, S_COUNT = 1, S_HOLD = 2, S_TO = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [PW-1:0]  tick_div;
  logic [CH-1:0]  start, hold, clear;
  logic [CH*CW-1:0] tset;
  logic [CH*CW-1:0] cnt_o, peak_o;
  logic [CH-1:0]  timeout_o, timeout_p_o, ovf_o, busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  ans_delay_timer_mc #(.CH_NUM(CH), .CNT_W(CW), .PRESC_W(PW)) dut (
    .clk(clk), .rst(rst_n), .tick_div_i(tick_div),
    .start_i(start), .hold_i(hold), .clear_i(clear), .timeout_set_i(tset),
    .cnt_o(cnt_o), .peak_o(peak_o), .timeout_o(timeout_o),
    .timeout_p_o(timeout_p_o), .ovf_o(ovf_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // Reference model: state per channel as plain integers
  int m_presc, mn_presc;
  bit m_tick;
  int m_st[CH], mn_st[CH], m_cnt[CH], mn_cnt[CH], m_peak[CH], mn_peak[CH];
  bit m_ovf[CH], mn_ovf[CH], m_pulse[CH], mn_pulse[CH];

  always_comb begin
    mn_st = m_st; mn_cnt = m_cnt; mn_peak = m_peak; mn_ovf = m_ovf;
    for (int c = 0; c < CH; c++) mn_pulse[c] = 1'b0;
    m_tick   = (m_presc == int'(tick_div));
    mn_presc = (m_presc >= int'(tick_div)) ? 0 : m_presc + 1;
    for (int c = 0; c < CH; c++) begin
      if (clear[c]) begin
        mn_st[c] = S_IDLE; mn_cnt[c] = 0; mn_peak[c] = 0; mn_ovf[c] = 1'b0;
      end else if (start[c]) begin
        mn_st[c] = S_COUNT; mn_cnt[c] = 0; mn_ovf[c] = 1'b0;
      end else if (m_st[c] == S_COUNT && hold[c]) begin
        mn_st[c] = S_HOLD;
        mn_peak[c] = (m_cnt[c] > m_peak[c]) ? m_cnt[c] : m_peak[c];
      end else if (m_st[c] == S_COUNT && m_tick) begin
        mn_cnt[c] = (m_cnt[c] + 1) % MOD;
        if (tset[c*CW +: CW] != 0 && mn_cnt[c] >= int'(tset[c*CW +: CW])) begin
          mn_st[c] = S_TO; mn_pulse[c] = 1'b1;
        end else if (mn_cnt[c] == MOD - 1) begin
          mn_st[c] = S_HOLD; mn_ovf[c] = 1'b1; mn_peak[c] = MOD - 1;
        end
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_presc <= 0;
      for (int c = 0; c < CH; c++) begin
        m_st[c] <= S_IDLE; m_cnt[c] <= 0; m_peak[c] <= 0; m_ovf[c] <= 1'b0; m_pulse[c] <= 1'b0;
      end
    end else begin
      m_presc <= mn_presc;
      m_st <= mn_st; m_cnt <= mn_cnt; m_peak <= mn_peak; m_ovf <= mn_ovf; m_pulse <= mn_pulse;
    end
  end

  task automatic clear_all();
    @(negedge clk); clear = '1;
    @(negedge clk); clear = '0;
  endtask

  task automatic test_reset();
    n_checks++; if (cnt_o !== '0) begin n_fail++; $display("FAIL reset_cnt got %h exp 0", cnt_o); end
    n_checks++; if (peak_o !== '0) begin n_fail++; $display("FAIL reset_peak got %h exp 0", peak_o); end
    n_checks++; if (timeout_o !== '0) begin n_fail++; $display("FAIL reset_timeout got %b exp 0", timeout_o); end
    n_checks++; if (timeout_p_o !== '0) begin n_fail++; $display("FAIL reset_pulse got %b exp 0", timeout_p_o); end
    n_checks++; if (ovf_o !== '0) begin n_fail++; $display("FAIL reset_ovf got %b exp 0", ovf_o); end
    n_checks++; if (busy_o !== '0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy_o); end
    $display("test_reset: outputs checked while reset held");
  endtask

  task automatic test_timeout();
    bit seen = 0;
    int edges = 0;
    tick_div = 9; tset = '0; tset[0 +: CW] = 8'd5;
    clear_all();
    start[0] = 1'b1; @(negedge clk); start[0] = 1'b0;
    n_checks++; if (busy_o[0] !== 1'b1) begin n_fail++; $display("FAIL to_busy_after_start got %b exp 1", busy_o[0]); end
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (timeout_p_o[0] === 1'b1) begin seen = 1; edges = i + 1; break; end
    end
    n_checks++;
    if (!seen) begin
      n_fail++; $display("FAIL to_pulse_seen got none within 200 clk exp pulse");
    end else begin
      n_checks++; if (edges < 41 || edges > 50) begin n_fail++; $display("FAIL to_latency got %0d exp 41..50", edges); end
      n_checks++; if (cnt_o[0 +: CW] !== 8'd5) begin n_fail++; $display("FAIL to_cnt got %0d exp 5", cnt_o[0 +: CW]); end
      @(negedge clk);
      n_checks++; if (timeout_p_o[0] !== 1'b0) begin n_fail++; $display("FAIL to_pulse_width got %b exp 0", timeout_p_o[0]); end
      n_checks++; if (timeout_o[0] !== 1'b1) begin n_fail++; $display("FAIL to_level got %b exp 1", timeout_o[0]); end
      n_checks++; if (busy_o[0] !== 1'b0) begin n_fail++; $display("FAIL to_busy got %b exp 0", busy_o[0]); end
      repeat (15) @(negedge clk);
      n_checks++; if (timeout_o[0] !== 1'b1 || cnt_o[0 +: CW] !== 8'd5) begin
        n_fail++; $display("FAIL to_held got lvl %b cnt %0d exp lvl 1 cnt 5", timeout_o[0], cnt_o[0 +: CW]);
      end
    end
    $display("test_timeout: pulse after %0d clk", edges);
  endtask

  task automatic test_hold_peak();
    tick_div = 0; tset = '0;
    clear_all();
    start[1] = 1'b1; @(negedge clk); start[1] = 1'b0;
    repeat (20) @(negedge clk);
    hold[1] = 1'b1; @(negedge clk); hold[1] = 1'b0;
    n_checks++; if (cnt_o[CW +: CW] !== 8'd20) begin n_fail++; $display("FAIL hold_cnt got %0d exp 20", cnt_o[CW +: CW]); end
    n_checks++; if (busy_o[1] !== 1'b0) begin n_fail++; $display("FAIL hold_busy got %b exp 0", busy_o[1]); end
    n_checks++; if (peak_o[CW +: CW] !== 8'd20) begin n_fail++; $display("FAIL hold_peak got %0d exp 20", peak_o[CW +: CW]); end
    start[1] = 1'b1; @(negedge clk); start[1] = 1'b0;
    repeat (7) @(negedge clk);
    hold[1] = 1'b1; @(negedge clk); hold[1] = 1'b0;
    n_checks++; if (cnt_o[CW +: CW] !== 8'd7) begin n_fail++; $display("FAIL hold2_cnt got %0d exp 7", cnt_o[CW +: CW]); end
    n_checks++; if (peak_o[CW +: CW] !== 8'd20) begin n_fail++; $display("FAIL hold2_peak got %0d exp 20", peak_o[CW +: CW]); end
    $display("test_hold_peak: done");
  endtask

  task automatic test_saturate();
    tick_div = 0; tset = '0;
    clear_all();
    start[2] = 1'b1; @(negedge clk); start[2] = 1'b0;
    repeat (254) @(negedge clk);
    n_checks++; if (cnt_o[2*CW +: CW] !== 8'd254 || busy_o[2] !== 1'b1 || ovf_o[2] !== 1'b0) begin
      n_fail++; $display("FAIL sat_pre got cnt %0d busy %b ovf %b exp 254 1 0", cnt_o[2*CW +: CW], busy_o[2], ovf_o[2]);
    end
    @(negedge clk);
    n_checks++; if (cnt_o[2*CW +: CW] !== 8'd255) begin n_fail++; $display("FAIL sat_cnt got %0d exp 255", cnt_o[2*CW +: CW]); end
    n_checks++; if (ovf_o[2] !== 1'b1) begin n_fail++; $display("FAIL sat_ovf got %b exp 1", ovf_o[2]); end
    n_checks++; if (busy_o[2] !== 1'b0 || timeout_o[2] !== 1'b0) begin
      n_fail++; $display("FAIL sat_state got busy %b to %b exp 0 0", busy_o[2], timeout_o[2]);
    end
    n_checks++; if (peak_o[2*CW +: CW] !== 8'd255) begin n_fail++; $display("FAIL sat_peak got %0d exp 255", peak_o[2*CW +: CW]); end
    $display("test_saturate: done");
  endtask

  task automatic test_priority();
    tick_div = 0; tset = '0;
    clear_all();
    start[3] = 1'b1; @(negedge clk); start[3] = 1'b0;
    repeat (4) @(negedge clk);
    hold[3] = 1'b1; @(negedge clk); hold[3] = 1'b0;
    n_checks++; if (peak_o[3*CW +: CW] !== 8'd4) begin n_fail++; $display("FAIL prio_peak_pre got %0d exp 4", peak_o[3*CW +: CW]); end
    start[3] = 1'b1; @(negedge clk); start[3] = 1'b0;
    repeat (3) @(negedge clk);
    start[3] = 1'b1; hold[3] = 1'b1; clear[3] = 1'b1;
    @(negedge clk);
    start[3] = 1'b0; hold[3] = 1'b0; clear[3] = 1'b0;
    n_checks++; if (busy_o[3] !== 1'b0 || cnt_o[3*CW +: CW] !== 8'd0 || peak_o[3*CW +: CW] !== 8'd0) begin
      n_fail++; $display("FAIL prio_clear got busy %b cnt %0d peak %0d exp 0 0 0", busy_o[3], cnt_o[3*CW +: CW], peak_o[3*CW +: CW]);
    end
    $display("test_priority: done");
  endtask

  task automatic test_multi();
    int pcnt[CH];
    int pcyc[CH];
    tick_div = 4;
    for (int c = 0; c < CH; c++) begin tset[c*CW +: CW] = 8'd10; pcnt[c] = 0; pcyc[c] = 0; end
    clear_all();
    for (int cyc = 0; cyc < 10; cyc++) begin
      for (int c = 0; c < CH; c++) start[c] = (cyc == 3 * c);
      @(negedge clk);
    end
    start = '0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      for (int c = 0; c < CH; c++) begin
        n_checks++; if (timeout_p_o[c] !== m_pulse[c]) begin
          n_fail++; $display("FAIL multi_pulse ch%0d cyc%0d got %b exp %b", c, i, timeout_p_o[c], m_pulse[c]);
        end
        if (timeout_p_o[c] === 1'b1) begin pcnt[c]++; pcyc[c] = i; end
      end
    end
    for (int c = 0; c < CH; c++) begin
      n_checks++; if (pcnt[c] != 1) begin n_fail++; $display("FAIL multi_count ch%0d got %0d exp 1", c, pcnt[c]); end
      n_checks++; if (cnt_o[c*CW +: CW] !== 8'd10 || timeout_o[c] !== 1'b1) begin
        n_fail++; $display("FAIL multi_final ch%0d got cnt %0d to %b exp 10 1", c, cnt_o[c*CW +: CW], timeout_o[c]);
      end
      if (c > 0) begin
        n_checks++; if (pcyc[c] - pcyc[c-1] != 0 && pcyc[c] - pcyc[c-1] != 5) begin
          n_fail++; $display("FAIL multi_spacing ch%0d got %0d exp 0 or 5", c, pcyc[c] - pcyc[c-1]);
        end
      end
    end
    $display("test_multi: pulse cycles %0d %0d %0d %0d", pcyc[0], pcyc[1], pcyc[2], pcyc[3]);
  endtask

  task automatic test_tmr();
    tick_div = 0; tset = '0;
    clear_all();
    start[0] = 1'b1; @(negedge clk); start[0] = 1'b0;
    repeat (5) @(negedge clk);
    force dut.gen_ch[0].r_st_a = 2'b00;
    @(negedge clk);
    n_checks++; if (busy_o[0] !== 1'b1 || cnt_o[0 +: CW] !== CW'(m_cnt[0])) begin
      n_fail++; $display("FAIL tmr_vote got busy %b cnt %0d exp 1 %0d", busy_o[0], cnt_o[0 +: CW], m_cnt[0]);
    end
    release dut.gen_ch[0].r_st_a;
    @(negedge clk);
    n_checks++; if (dut.gen_ch[0].r_st_a !== 2'b01) begin
      n_fail++; $display("FAIL tmr_repair got %b exp 01", dut.gen_ch[0].r_st_a);
    end
    n_checks++; if (busy_o[0] !== 1'b1 || cnt_o[0 +: CW] !== CW'(m_cnt[0])) begin
      n_fail++; $display("FAIL tmr_after got busy %b cnt %0d exp 1 %0d", busy_o[0], cnt_o[0 +: CW], m_cnt[0]);
    end
    $display("test_tmr: done");
  endtask

  task automatic test_random();
    int r;
    tick_div = 1;
    for (int c = 0; c < CH; c++) tset[c*CW +: CW] = CW'($urandom_range(0, 40));
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      for (int c = 0; c < CH; c++) begin
        n_checks++; if (cnt_o[c*CW +: CW] !== CW'(m_cnt[c])) begin
          n_fail++; $display("FAIL rand_cnt ch%0d cyc%0d got %0d exp %0d", c, cyc, cnt_o[c*CW +: CW], m_cnt[c]);
        end
        n_checks++; if (peak_o[c*CW +: CW] !== CW'(m_peak[c])) begin
          n_fail++; $display("FAIL rand_peak ch%0d cyc%0d got %0d exp %0d", c, cyc, peak_o[c*CW +: CW], m_peak[c]);
        end
        n_checks++; if (timeout_o[c] !== (m_st[c] == S_TO) || busy_o[c] !== (m_st[c] == S_COUNT)) begin
          n_fail++; $display("FAIL rand_state ch%0d cyc%0d got to %b busy %b exp state %0d", c, cyc, timeout_o[c], busy_o[c], m_st[c]);
        end
        n_checks++; if (timeout_p_o[c] !== m_pulse[c] || ovf_o[c] !== m_ovf[c]) begin
          n_fail++; $display("FAIL rand_flags ch%0d cyc%0d got p %b ovf %b exp p %b ovf %b", c, cyc, timeout_p_o[c], ovf_o[c], m_pulse[c], m_ovf[c]);
        end
      end
      start = '0; hold = '0; clear = '0;
      for (int c = 0; c < CH; c++) begin
        r = $urandom_range(0, 99);
        if (r < 3) start[c] = 1'b1;
        else if (r < 10) hold[c] = 1'b1;
        else if (r == 10) clear[c] = 1'b1;
        else if (r == 99) begin start[c] = 1'b1; hold[c] = 1'b1; clear[c] = 1'b1; end
        if ($urandom_range(0, 99) == 0) tset[c*CW +: CW] = CW'($urandom_range(0, 40));
      end
      if ($urandom_range(0, 199) == 0) tick_div = PW'($urandom_range(0, 3));
    end
    start = '0; hold = '0; clear = '0;
    $display("test_random: 1500 cycles compared");
  endtask

  task automatic test_reset_midcount();
    tick_div = 0; tset = '0;
    clear_all();
    start[1:0] = 2'b11; @(negedge clk); start = '0;
    repeat (10) @(negedge clk);
    n_checks++; if (busy_o[1:0] !== 2'b11) begin n_fail++; $display("FAIL rstmid_pre got %b exp 11", busy_o[1:0]); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (cnt_o !== '0 || busy_o !== '0 || timeout_p_o !== '0 || peak_o !== '0) begin
      n_fail++; $display("FAIL rstmid_async got cnt %h busy %b p %b exp 0", cnt_o, busy_o, timeout_p_o);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (busy_o !== '0 || cnt_o !== '0) begin
      n_fail++; $display("FAIL rstmid_idle got busy %b cnt %h exp 0", busy_o, cnt_o);
    end
    $display("test_reset_midcount: done");
  endtask

  initial begin
    rst_n = 1'b0; tick_div = '0; start = '0; hold = '0; clear = '0; tset = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_timeout();
    test_hold_peak();
    test_saturate();
    test_priority();
    test_multi();
    test_tmr();
    test_random();
    test_reset_midcount();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
